// File: rtl/dbus_simple_master_if.sv
// Request-side and dBus signals of dbus_simple_master bundled into one interface.
// The master modport is the initiator's view; slave is the memory stage plus responder view.
interface dbus_simple_master_if;
   logic        req_valid;
   logic        req_ready;
   logic        req_wr;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic [1:0]  req_size;
   logic        req_unsigned;
   logic        done_valid;
   logic [31:0] done_rdata;
   logic        done_trap;
   logic        done_error;
   logic        dBus_cmd_valid;
   logic        dBus_cmd_ready;
   logic        dBus_cmd_payload_wr;
   logic [31:0] dBus_cmd_payload_address;
   logic [31:0] dBus_cmd_payload_data;
   logic [1:0]  dBus_cmd_payload_size;
   logic        dBus_rsp_ready;
   logic [31:0] dBus_rsp_data;
   logic        dBus_rsp_error;

   modport master (
      input  req_valid, req_wr, req_addr, req_wdata, req_size, req_unsigned,
      input  dBus_cmd_ready, dBus_rsp_ready, dBus_rsp_data, dBus_rsp_error,
      output req_ready, done_valid, done_rdata, done_trap, done_error,
      output dBus_cmd_valid, dBus_cmd_payload_wr, dBus_cmd_payload_address,
      output dBus_cmd_payload_data, dBus_cmd_payload_size
   );

   modport slave (
      output req_valid, req_wr, req_addr, req_wdata, req_size, req_unsigned,
      output dBus_cmd_ready, dBus_rsp_ready, dBus_rsp_data, dBus_rsp_error,
      input  req_ready, done_valid, done_rdata, done_trap, done_error,
      input  dBus_cmd_valid, dBus_cmd_payload_wr, dBus_cmd_payload_address,
      input  dBus_cmd_payload_data, dBus_cmd_payload_size
   );
endinterface

// File: rtl/dbus_simple_master.sv
// Single-outstanding dBus initiator: issues load/store commands and returns aligned, extended load data.
// Define DBUS_SIMPLE_MASTER_MISALIGN_TRAP_EN to trap misaligned and illegal-size requests.
module dbus_simple_master #(
   parameter int unsigned RSP_TIMEOUT = 255
) (
   input logic clk,
   input logic reset,
   dbus_simple_master_if.master bus
);

   typedef enum logic [1:0] {IDLE, CMD, RSP, DONE} state_t;

   localparam logic [31:0] TimeoutLast = 32'(RSP_TIMEOUT - 1);

   state_t      state;
   logic [1:0]  addrLow;
   logic [1:0]  sizeReg;
   logic        unsignedReg;
   logic [31:0] rspCount;
   logic        reqTrap;
   logic [1:0]  reqSizeEff;

   function automatic logic [31:0] replicateData(input logic [31:0] data, input logic [1:0] size);
      logic [31:0] result;
      case (size)
         2'd0:    result = {4{data[7:0]}};
         2'd1:    result = {2{data[15:0]}};
         default: result = data;
      endcase
      return result;
   endfunction

   // Bytes shifted past lane 3 by a misaligned offset simply fall off the top.
   function automatic logic [31:0] extractLoad(input logic [31:0] raw, input logic [1:0] offset,
                                               input logic [1:0] size, input logic isUnsigned);
      logic [31:0] shifted;
      logic [31:0] result;
      shifted = raw >> {offset, 3'b000};
      case (size)
         2'd0:    result = isUnsigned ? {24'd0, shifted[7:0]} : {{24{shifted[7]}}, shifted[7:0]};
         2'd1:    result = isUnsigned ? {16'd0, shifted[15:0]} : {{16{shifted[15]}}, shifted[15:0]};
         default: result = shifted;
      endcase
      return result;
   endfunction

   always_comb begin
      reqTrap = 1'b0;
`ifdef DBUS_SIMPLE_MASTER_MISALIGN_TRAP_EN
      case (bus.req_size)
         2'd1:    reqTrap = bus.req_addr[0];
         2'd2:    reqTrap = |bus.req_addr[1:0];
         2'd3:    reqTrap = 1'b1;
         default: reqTrap = 1'b0;
      endcase
`endif
   end

   assign reqSizeEff = (bus.req_size == 2'd3) ? 2'd2 : bus.req_size;

   // All outputs are registered and updated together with the state transition.
   always_ff @(posedge clk) begin
      if (reset) begin
         state                        <= IDLE;
         addrLow                      <= 2'd0;
         sizeReg                      <= 2'd0;
         unsignedReg                  <= 1'b0;
         rspCount                     <= 32'd0;
         bus.req_ready                <= 1'b1;
         bus.done_valid               <= 1'b0;
         bus.done_rdata               <= 32'd0;
         bus.done_trap                <= 1'b0;
         bus.done_error               <= 1'b0;
         bus.dBus_cmd_valid           <= 1'b0;
         bus.dBus_cmd_payload_wr      <= 1'b0;
         bus.dBus_cmd_payload_address <= 32'd0;
         bus.dBus_cmd_payload_data    <= 32'd0;
         bus.dBus_cmd_payload_size    <= 2'd0;
      end else begin
         bus.done_valid <= 1'b0;
         case (state)
            IDLE: begin
               if (bus.req_valid) begin
                  bus.req_ready <= 1'b0;
                  addrLow       <= bus.req_addr[1:0];
                  sizeReg       <= reqSizeEff;
                  unsignedReg   <= bus.req_unsigned;
                  if (reqTrap) begin
                     state          <= DONE;
                     bus.done_valid <= 1'b1;
                     bus.done_trap  <= 1'b1;
                     bus.done_error <= 1'b0;
                     bus.done_rdata <= 32'd0;
                  end else begin
                     state                        <= CMD;
                     bus.dBus_cmd_valid           <= 1'b1;
                     bus.dBus_cmd_payload_wr      <= bus.req_wr;
                     bus.dBus_cmd_payload_address <= bus.req_addr;
                     bus.dBus_cmd_payload_data    <= replicateData(bus.req_wdata, reqSizeEff);
                     bus.dBus_cmd_payload_size    <= reqSizeEff;
                  end
               end
            end
            CMD: begin
               if (bus.dBus_cmd_ready) begin
                  bus.dBus_cmd_valid <= 1'b0;
                  if (bus.dBus_cmd_payload_wr) begin
                     state          <= DONE;
                     bus.done_valid <= 1'b1;
                     bus.done_trap  <= 1'b0;
                     bus.done_error <= 1'b0;
                     bus.done_rdata <= 32'd0;
                  end else begin
                     state    <= RSP;
                     rspCount <= 32'd0;
                  end
               end
            end
            RSP: begin
               if (bus.dBus_rsp_ready) begin
                  state          <= DONE;
                  bus.done_valid <= 1'b1;
                  bus.done_trap  <= 1'b0;
                  bus.done_error <= bus.dBus_rsp_error;
                  bus.done_rdata <= bus.dBus_rsp_error ? 32'd0
                                    : extractLoad(bus.dBus_rsp_data, addrLow, sizeReg, unsignedReg);
               end else if ((RSP_TIMEOUT != 0) && (rspCount == TimeoutLast)) begin
                  state          <= DONE;
                  bus.done_valid <= 1'b1;
                  bus.done_trap  <= 1'b0;
                  bus.done_error <= 1'b1;
                  bus.done_rdata <= 32'd0;
               end else begin
                  rspCount <= rspCount + 32'd1;
               end
            end
            DONE: begin
               state          <= IDLE;
               bus.req_ready  <= 1'b1;
               bus.done_trap  <= 1'b0;
               bus.done_error <= 1'b0;
               bus.done_rdata <= 32'd0;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_dbus_simple_master.sv
// Directed testbench for dbus_simple_master: stores, loads, lane handling, timeout, bus error and reset abort.
// Built with RSP_TIMEOUT = 4; trap expectations follow DBUS_SIMPLE_MASTER_MISALIGN_TRAP_EN.
module tb_dbus_simple_master;

   logic clk;
   logic reset;
   int   checks;
   int   failures;
   int   handshakes;
   int   donePulses;

   dbus_simple_master_if bus ();

   dbus_simple_master #(.RSP_TIMEOUT(4)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (bus.dBus_cmd_valid && bus.dBus_cmd_ready) handshakes++;
      if (bus.done_valid) donePulses++;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      assert (observed === expected)
      else begin
         failures++;
         $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
      end
   endtask

   // Presents a request for one cycle (cycle 0) and leaves the bench in cycle 1.
   task automatic applyStimulus(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                                input logic [1:0] size, input logic isUnsigned);
      bus.req_wr       = wr;
      bus.req_addr     = addr;
      bus.req_wdata    = wdata;
      bus.req_size     = size;
      bus.req_unsigned = isUnsigned;
      bus.req_valid    = 1'b1;
      tick();
      bus.req_valid    = 1'b0;
   endtask

   initial begin
      int hsBefore;
      int doneBefore;
      checks     = 0;
      failures   = 0;
      handshakes = 0;
      donePulses = 0;
      reset              = 1'b1;
      bus.req_valid      = 1'b0;
      bus.req_wr         = 1'b0;
      bus.req_addr       = 32'd0;
      bus.req_wdata      = 32'd0;
      bus.req_size       = 2'd0;
      bus.req_unsigned   = 1'b0;
      bus.dBus_cmd_ready = 1'b0;
      bus.dBus_rsp_ready = 1'b0;
      bus.dBus_rsp_data  = 32'd0;
      bus.dBus_rsp_error = 1'b0;
      tick();
      tick();
      checkOutput("rst_req_ready", bus.req_ready, 1);
      checkOutput("rst_done_valid", bus.done_valid, 0);
      checkOutput("rst_cmd_valid", bus.dBus_cmd_valid, 0);
      checkOutput("rst_done_rdata", bus.done_rdata, 0);
      checkOutput("rst_cmd_addr", bus.dBus_cmd_payload_address, 0);
      reset = 1'b0;
      tick();
      handshakes = 0;
      donePulses = 0;

      // Word store, cmd_ready held high
      bus.dBus_cmd_ready = 1'b1;
      applyStimulus(1'b1, 32'h100, 32'hDEADBEEF, 2'd2, 1'b0);
      checkOutput("sw_cmd_valid", bus.dBus_cmd_valid, 1);
      checkOutput("sw_cmd_wr", bus.dBus_cmd_payload_wr, 1);
      checkOutput("sw_cmd_size", bus.dBus_cmd_payload_size, 2);
      checkOutput("sw_cmd_addr", bus.dBus_cmd_payload_address, 32'h100);
      checkOutput("sw_cmd_data", bus.dBus_cmd_payload_data, 32'hDEADBEEF);
      checkOutput("sw_req_ready_busy", bus.req_ready, 0);
      tick();
      checkOutput("sw_done_valid", bus.done_valid, 1);
      checkOutput("sw_done_rdata", bus.done_rdata, 0);
      checkOutput("sw_done_error", bus.done_error, 0);
      checkOutput("sw_cmd_dropped", bus.dBus_cmd_valid, 0);
      tick();
      checkOutput("sw_req_ready_back", bus.req_ready, 1);
      checkOutput("sw_done_pulse_end", bus.done_valid, 0);

      // LB at 0x103, response two cycles after the handshake
      applyStimulus(1'b0, 32'h103, 32'd0, 2'd0, 1'b0);
      checkOutput("lb_cmd_addr", bus.dBus_cmd_payload_address, 32'h103);
      checkOutput("lb_cmd_size", bus.dBus_cmd_payload_size, 0);
      checkOutput("lb_cmd_wr", bus.dBus_cmd_payload_wr, 0);
      tick();
      checkOutput("lb_wait_done", bus.done_valid, 0);
      tick();
      bus.dBus_rsp_ready = 1'b1;
      bus.dBus_rsp_data  = 32'h80123456;
      tick();
      bus.dBus_rsp_ready = 1'b0;
      checkOutput("lb_done_valid", bus.done_valid, 1);
      checkOutput("lb_done_rdata", bus.done_rdata, 32'hFFFFFF80);
      tick();

      // LBU at 0x103, earliest response
      applyStimulus(1'b0, 32'h103, 32'd0, 2'd0, 1'b1);
      tick();
      bus.dBus_rsp_ready = 1'b1;
      tick();
      bus.dBus_rsp_ready = 1'b0;
      checkOutput("lbu_done_valid", bus.done_valid, 1);
      checkOutput("lbu_done_rdata", bus.done_rdata, 32'h00000080);
      tick();

      // LH at 0x102 picks the upper half and sign-extends
      applyStimulus(1'b0, 32'h102, 32'd0, 2'd1, 1'b0);
      tick();
      bus.dBus_rsp_ready = 1'b1;
      bus.dBus_rsp_data  = 32'h9ABC1234;
      tick();
      bus.dBus_rsp_ready = 1'b0;
      checkOutput("lh_done_rdata", bus.done_rdata, 32'hFFFF9ABC);
      tick();

      // Half store with cmd_ready low for 3 cycles
      bus.dBus_cmd_ready = 1'b0;
      hsBefore = handshakes;
      applyStimulus(1'b1, 32'h202, 32'h0000ABCD, 2'd1, 1'b0);
      for (int i = 0; i < 3; i++) begin
         checkOutput($sformatf("sh_hold_valid%0d", i), bus.dBus_cmd_valid, 1);
         checkOutput($sformatf("sh_hold_data%0d", i), bus.dBus_cmd_payload_data, 32'hABCDABCD);
         checkOutput($sformatf("sh_hold_addr%0d", i), bus.dBus_cmd_payload_address, 32'h202);
         checkOutput($sformatf("sh_hold_size%0d", i), bus.dBus_cmd_payload_size, 1);
         tick();
      end
      checkOutput("sh_valid_at_ready", bus.dBus_cmd_valid, 1);
      bus.dBus_cmd_ready = 1'b1;
      tick();
      checkOutput("sh_done_valid", bus.done_valid, 1);
      checkOutput("sh_cmd_dropped", bus.dBus_cmd_valid, 0);
      tick();
      checkOutput("sh_handshakes", handshakes - hsBefore, 1);

      // Byte store replicates to every lane
      applyStimulus(1'b1, 32'h301, 32'h000000A5, 2'd0, 1'b0);
      checkOutput("sb_cmd_data", bus.dBus_cmd_payload_data, 32'hA5A5A5A5);
      tick();
      tick();

      // Misaligned word load at 0x101
      hsBefore = handshakes;
      applyStimulus(1'b0, 32'h101, 32'd0, 2'd2, 1'b0);
`ifdef DBUS_SIMPLE_MASTER_MISALIGN_TRAP_EN
      checkOutput("mis_done_valid", bus.done_valid, 1);
      checkOutput("mis_done_trap", bus.done_trap, 1);
      checkOutput("mis_no_cmd", bus.dBus_cmd_valid, 0);
      tick();
      checkOutput("mis_no_handshake", handshakes - hsBefore, 0);
`else
      checkOutput("mis_cmd_addr", bus.dBus_cmd_payload_address, 32'h101);
      checkOutput("mis_cmd_size", bus.dBus_cmd_payload_size, 2);
      tick();
      bus.dBus_rsp_ready = 1'b1;
      bus.dBus_rsp_data  = 32'h11223344;
      tick();
      bus.dBus_rsp_ready = 1'b0;
      checkOutput("mis_done_rdata", bus.done_rdata, 32'h00112233);
      checkOutput("mis_done_trap", bus.done_trap, 0);
`endif
      tick();

      // Illegal size 3 store
      applyStimulus(1'b1, 32'h10, 32'h12345678, 2'd3, 1'b0);
`ifdef DBUS_SIMPLE_MASTER_MISALIGN_TRAP_EN
      checkOutput("sz3_done_trap", bus.done_trap, 1);
      checkOutput("sz3_no_cmd", bus.dBus_cmd_valid, 0);
      tick();
`else
      checkOutput("sz3_cmd_size", bus.dBus_cmd_payload_size, 2);
      checkOutput("sz3_cmd_data", bus.dBus_cmd_payload_data, 32'h12345678);
      tick();
      tick();
`endif
      tick();

      // Response timeout: RSP entered in cycle 2, done_error in cycle 6
      applyStimulus(1'b0, 32'h40, 32'd0, 2'd2, 1'b0);
      tick();
      for (int i = 0; i < 4; i++) begin
         checkOutput($sformatf("to_wait%0d", i), bus.done_valid, 0);
         tick();
      end
      checkOutput("to_done_valid", bus.done_valid, 1);
      checkOutput("to_done_error", bus.done_error, 1);
      checkOutput("to_done_rdata", bus.done_rdata, 0);
      tick();
      checkOutput("to_req_ready", bus.req_ready, 1);

      // Bus error response
      applyStimulus(1'b0, 32'h44, 32'd0, 2'd2, 1'b0);
      tick();
      bus.dBus_rsp_ready = 1'b1;
      bus.dBus_rsp_error = 1'b1;
      bus.dBus_rsp_data  = 32'hFFFFFFFF;
      tick();
      bus.dBus_rsp_ready = 1'b0;
      bus.dBus_rsp_error = 1'b0;
      checkOutput("err_done_valid", bus.done_valid, 1);
      checkOutput("err_done_error", bus.done_error, 1);
      checkOutput("err_done_rdata", bus.done_rdata, 0);
      tick();

      // Reset while waiting in RSP abandons the load
      applyStimulus(1'b0, 32'h48, 32'd0, 2'd2, 1'b0);
      tick();
      checkOutput("rr_in_rsp_busy", bus.req_ready, 0);
      doneBefore = donePulses;
      reset = 1'b1;
      tick();
      reset = 1'b0;
      checkOutput("rr_req_ready", bus.req_ready, 1);
      checkOutput("rr_done_valid", bus.done_valid, 0);
      for (int i = 0; i < 6; i++) tick();
      checkOutput("rr_no_done_pulse", donePulses - doneBefore, 0);
      checkOutput("rr_idle_cmd", bus.dBus_cmd_valid, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/dbus_simple_master.md
# dbus_simple_master

Initiator for the core's simple data bus (dBus cmd/rsp). Accepts one load/store request at a time from the memory stage and drives the matching dBus command, including size, address and lane-replicated write data. For loads it waits for the read response, then aligns and sign- or zero-extends the data before returning it. It is the master counterpart to the dBus memory responders used by the formal and simulation benches, and holds at most one transaction in flight.

## Interface
Parameters:
- RSP_TIMEOUT, 255: maximum cycles spent waiting for a read response. 0 disables the timeout.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- req_valid  in  1  memory-stage request valid
- req_ready  out  1  high only in IDLE
- req_wr  in  1  1 = store, 0 = load
- req_addr  in  32  byte address
- req_wdata  in  32  store data, right-aligned
- req_size  in  2  0 = byte, 1 = half, 2 = word, 3 = illegal
- req_unsigned  in  1  zero-extend load result (LBU/LHU)
- done_valid  out  1  one-cycle completion pulse
- done_rdata  out  32  extended load data; 0 for stores, traps and errors
- done_trap  out  1  misaligned or illegal-size request
- done_error  out  1  bus error or response timeout
- dBus_cmd_valid  out  1  command valid
- dBus_cmd_ready  in  1  command accepted
- dBus_cmd_payload_wr  out  1  write command
- dBus_cmd_payload_address  out  32  byte address, unmodified
- dBus_cmd_payload_data  out  32  lane-replicated write data
- dBus_cmd_payload_size  out  2  log2 of byte count
- dBus_rsp_ready  in  1  read response valid (asserted for reads only)
- dBus_rsp_data  in  32  raw word read from the bus
- dBus_rsp_error  in  1  response error

## Operation
State machine states: IDLE, CMD, RSP, DONE.

- **IDLE**
  - req_ready = 1.
  - On req_valid, capture all request fields.
  - Go to DONE with trap if the access is misaligned (see Configuration). Otherwise go to CMD.
- **CMD**
  - dBus_cmd_valid = 1 with all payload held stable until the dBus_cmd_ready handshake.
  - On handshake: a store goes to DONE; a load goes to RSP.
- **RSP**
  - dBus_rsp_ready is sampled only in this state.
  - On dBus_rsp_ready, capture the extended data and dBus_rsp_error, then go to DONE.
  - A timeout counter starts at 0 on entry and increments each cycle. When it reaches RSP_TIMEOUT (nonzero), go to DONE with done_error = 1 and done_rdata = 0.
- **DONE**
  - done_valid = 1 for exactly one cycle, with the result flags, then return to IDLE.

Write data replication:
- size 0: data[7:0] replicated to all 4 lanes.
- size 1: data[15:0] replicated to both halves.
- size 2: data passed through.

Load extraction:
- Shift the raw word right by addr[1:0]*8.
- Take 8 or 16 bits per size.
- Sign-extend unless req_unsigned; size 2 takes the full word.

Outputs and reset:
- All outputs are registered.
- Reset values: every output is 0 except req_ready, which is 1 (state IDLE).
- Reset in any state returns to IDLE and abandons the in-flight transaction. No done_valid is produced for the abandoned transaction.

## Timing
- Request accepted in cycle 0 leads to dBus_cmd_valid in cycle 1.
- Store with dBus_cmd_ready in cycle 1: done_valid in cycle 2, req_ready high again in cycle 3.
- Load: the responder must not assert dBus_rsp_ready in the cmd handshake cycle. The earliest response is cycle 2, giving done_valid in cycle 3.
- Trapped request accepted in cycle 0: done_valid in cycle 1, and no dBus command is issued.
- dBus_cmd_valid never drops before dBus_cmd_ready, and the payload never changes while valid.
- After a timeout, a late dBus_rsp_ready is ignored in IDLE and CMD. Responders must not respond after a timeout.

## Configuration
- DBUS_SIMPLE_MASTER_MISALIGN_TRAP_EN defined:
  - Misaligned requests trap with no bus command: half with addr[0] = 1, word with addr[1:0] != 0.
  - req_size = 3 also traps.
- Undefined:
  - done_trap is tied to 0.
  - Misaligned accesses are issued unmodified; lanes beyond byte 3 are dropped.
  - req_size = 3 is issued as a word access.

## Test plan
- Word store: addr 0x100, data 0xDEADBEEF, cmd_ready held high → cmd in cycle 1 with size 2 and data 0xDEADBEEF; done_valid in cycle 2 with done_rdata 0.
- Byte load LB: addr 0x103, rsp_data 0x80123456 two cycles after the handshake → done_rdata 0xFFFFFF80. The same access as LBU → 0x00000080.
- Half store: addr 0x202, data 0x0000ABCD, cmd_ready low for 3 cycles → cmd_valid and payload stable for those 3 cycles; payload data 0xABCDABCD; exactly one handshake.
- Misaligned word load at 0x101 (macro defined) → done_valid and done_trap in cycle 1; dBus_cmd_valid never asserts.
- Load with no response and RSP_TIMEOUT = 4 → done_error = 1 exactly 4 cycles after entering RSP. Load with dBus_rsp_error = 1 → done_error = 1.
- Reset asserted in RSP → next cycle state is IDLE, req_ready = 1, and no done_valid is produced.
